// File: rtl/cdb_arbiter_if.sv
// Result buses from the ALU and LSB into the CDB arbiter,
// and the broadcast CDB back out to its consumers.
interface cdb_arbiter_if #(
    parameter int ROB_W = 4
);
    logic             alu_valid;
    logic [ROB_W-1:0] alu_tag;
    logic [31:0]      alu_val;
    logic             alu_ready;
    logic             lsb_valid;
    logic [ROB_W-1:0] lsb_tag;
    logic [31:0]      lsb_val;
    logic             lsb_ready;
    logic             cdb_valid;
    logic [ROB_W-1:0] cdb_tag;
    logic [31:0]      cdb_val;

    modport master (
        output alu_valid, alu_tag, alu_val,
        input  alu_ready,
        output lsb_valid, lsb_tag, lsb_val,
        input  lsb_ready,
        input  cdb_valid, cdb_tag, cdb_val
    );

    modport slave (
        input  alu_valid, alu_tag, alu_val,
        output alu_ready,
        input  lsb_valid, lsb_tag, lsb_val,
        output lsb_ready,
        output cdb_valid, cdb_tag, cdb_val
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between
// the ALU and LSB, each buffered by a small result FIFO.
module cdb_arbiter #(
    parameter int ROB_W = 4,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          rollback,
    cdb_arbiter_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    logic [ROB_W-1:0] tag_mem [2][DEPTH];
    logic [31:0]      val_mem [2][DEPTH];
    logic [PW-1:0]    wr_ptr  [2];
    logic [PW-1:0]    rd_ptr  [2];
    logic [CW-1:0]    count   [2];

    logic             in_valid [2];
    logic [ROB_W-1:0] in_tag   [2];
    logic [31:0]      in_val   [2];
    logic             ready    [2];
    logic             push     [2];
    logic             pop      [2];
    logic             ne_alu;
    logic             ne_lsb;

    src_e             last_grant;
    src_e             grant_src;
    logic             grant;

    logic             cdb_valid_q;
    logic [ROB_W-1:0] cdb_tag_q;
    logic [31:0]      cdb_val_q;

    assign bus.alu_ready = ready[0];
    assign bus.lsb_ready = ready[1];
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_val   = cdb_val_q;

    // Source inputs indexed by source; ready looks only at stored count.
    always_comb begin
        in_valid[0] = bus.alu_valid;
        in_tag[0]   = bus.alu_tag;
        in_val[0]   = bus.alu_val;
        in_valid[1] = bus.lsb_valid;
        in_tag[1]   = bus.lsb_tag;
        in_val[1]   = bus.lsb_val;
        for (int s = 0; s < 2; s++) begin
            ready[s] = (count[s] != CW'(DEPTH));
            push[s]  = in_valid[s] && ready[s];
        end
    end

    // Grant from registered FIFO occupancy; alternate on contention.
    always_comb begin
        grant     = 1'b0;
        grant_src = SRC_ALU;
        ne_alu    = (count[0] != '0);
        ne_lsb    = (count[1] != '0);
        unique case (1'b1)
            ne_alu && ne_lsb: begin
                grant     = 1'b1;
                grant_src = (last_grant == SRC_LSB) ? SRC_ALU : SRC_LSB;
            end
            ne_alu && !ne_lsb: begin
                grant     = 1'b1;
                grant_src = SRC_ALU;
            end
            !ne_alu && ne_lsb: begin
                grant     = 1'b1;
                grant_src = SRC_LSB;
            end
            default: ;
        endcase
        pop[0] = grant && (grant_src == SRC_ALU);
        pop[1] = grant && (grant_src == SRC_LSB);
    end

    // Entry storage; stale data is harmless since counts gate reads.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !rollback) begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    tag_mem[s][wr_ptr[s]] <= in_tag[s];
                    val_mem[s][wr_ptr[s]] <= in_val[s];
                end
            end
        end
    end

    // Pointers, counts, round-robin state and the registered broadcast.
    always_ff @(posedge clk) begin
        if (rst || (rdy && rollback)) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                count[s]  <= '0;
            end
            last_grant  <= SRC_LSB;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_val_q   <= '0;
        end else if (rdy) begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
                if (push[s] && !pop[s])
                    count[s] <= count[s] + CW'(1);
                else if (!push[s] && pop[s])
                    count[s] <= count[s] - CW'(1);
            end
            if (grant) begin
                last_grant  <= grant_src;
                cdb_valid_q <= 1'b1;
                cdb_tag_q   <= tag_mem[grant_src][rd_ptr[grant_src]];
                cdb_val_q   <= val_mem[grant_src][rd_ptr[grant_src]];
            end else begin
                cdb_valid_q <= 1'b0;
                cdb_tag_q   <= '0;
                cdb_val_q   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts are
// queued as stimulus is driven and checked as the CDB fires.
module tb_cdb_arbiter;
    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] val;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic rollback = 1'b0;
    logic rdy_q = 1'b0;
    int   errors = 0;
    int   checks = 0;
    res_t expq[$];

    cdb_arbiter_if #(.ROB_W(4)) bus ();

    cdb_arbiter #(.ROB_W(4), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Remember whether the last edge could load a new broadcast.
    always @(posedge clk) rdy_q <= rdy && !rst;

    // Scoreboard: every fresh broadcast must match the queue head.
    always @(negedge clk) begin
        if (bus.cdb_valid && rdy_q) begin
            res_t got;
            res_t exp;
            got = '{tag: bus.cdb_tag, val: bus.cdb_val};
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL cdb_unexpected got tag=%0d val=%h want none",
                         got.tag, got.val);
            end else begin
                exp = expq.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL cdb_order got tag=%0d val=%h want tag=%0d val=%h",
                             got.tag, got.val, exp.tag, exp.val);
                end
            end
        end
    end

    function automatic logic [31:0] aval(input logic [3:0] t);
        return 32'hA000_0000 | {28'd0, t};
    endfunction

    function automatic logic [31:0] lval(input logic [3:0] t);
        return 32'hB000_0000 | {28'd0, t};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [3:0] t);
        bus.alu_valid = v;
        bus.alu_tag   = t;
        bus.alu_val   = aval(t);
    endtask

    task automatic lsb(input logic v, input logic [3:0] t);
        bus.lsb_valid = v;
        bus.lsb_tag   = t;
        bus.lsb_val   = lval(t);
    endtask

    task automatic exp_a(input logic [3:0] t);
        expq.push_back('{tag: t, val: aval(t)});
    endtask

    task automatic exp_l(input logic [3:0] t);
        expq.push_back('{tag: t, val: lval(t)});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        rollback = 1'b0;
        alu(1'b0, 4'd0);
        lsb(1'b0, 4'd0);
        cyc();
        rst = 1'b0;
    endtask

    task automatic drained(input string name);
        checks++;
        if (expq.size() !== 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending want 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic idle_outputs(input string name);
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid got %b want 0", name, bus.cdb_valid);
        end
        checks++;
        if (bus.cdb_tag !== 4'd0) begin
            errors++;
            $display("FAIL %s_tag got %0d want 0", name, bus.cdb_tag);
        end
        checks++;
        if (bus.cdb_val !== 32'd0) begin
            errors++;
            $display("FAIL %s_val got %h want 0", name, bus.cdb_val);
        end
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.lsb_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready got %b%b want 11", name,
                     bus.alu_ready, bus.lsb_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu(1'b1, 4'd5);
        lsb(1'b1, 4'd6);
        cyc();
        cyc();
        alu(1'b0, 4'd0);
        lsb(1'b0, 4'd0);
        idle_outputs("reset");
        rst = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_latency();
        do_reset();
        expq.push_back('{tag: 4'd3, val: 32'h11});
        bus.alu_valid = 1'b1;
        bus.alu_tag   = 4'd3;
        bus.alu_val   = 32'h11;
        cyc();
        alu(1'b0, 4'd0);
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early got %b want 0", bus.cdb_valid);
        end
        cyc();
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 4'd3 || bus.cdb_val !== 32'h11) begin
            errors++;
            $display("FAIL lat_hit got v=%b tag=%0d val=%h want v=1 tag=3 val=11",
                     bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
        end
        cyc();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_once got %b want 0", bus.cdb_valid);
        end
        drained("lat");
    endtask

    task automatic test_back_to_back();
        logic ar[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic lr[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] ai;
        logic [3:0] li;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            exp_a(4'(i));
            exp_l(4'(8 + i));
        end
        ai = 4'd1;
        li = 4'd9;
        for (int k = 0; k < 6; k++) begin
            alu(1'b1, ai);
            lsb(1'b1, li);
            checks++;
            if (bus.alu_ready !== ar[k]) begin
                errors++;
                $display("FAIL b2b_alu_ready cyc%0d got %b want %b",
                         k, bus.alu_ready, ar[k]);
            end
            checks++;
            if (bus.lsb_ready !== lr[k]) begin
                errors++;
                $display("FAIL b2b_lsb_ready cyc%0d got %b want %b",
                         k, bus.lsb_ready, lr[k]);
            end
            if (ar[k]) ai = ai + 4'd1;
            if (lr[k]) li = li + 4'd1;
            cyc();
        end
        alu(1'b0, 4'd0);
        lsb(1'b0, 4'd0);
        repeat (5) cyc();
        drained("b2b");
    endtask

    task automatic test_full();
        do_reset();
        exp_a(4'd5);
        exp_l(4'd9);
        exp_a(4'd1);
        exp_l(4'd10);
        exp_a(4'd2);
        alu(1'b1, 4'd5);
        cyc();
        alu(1'b0, 4'd0);
        cyc();
        alu(1'b1, 4'd1);
        lsb(1'b1, 4'd9);
        cyc();
        alu(1'b1, 4'd2);
        lsb(1'b1, 4'd10);
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pre got %b want 1", bus.alu_ready);
        end
        cyc();
        alu(1'b1, 4'd3);
        lsb(1'b0, 4'd0);
        checks++;
        if (bus.alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", bus.alu_ready);
        end
        cyc();
        alu(1'b0, 4'd0);
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_return got %b want 1", bus.alu_ready);
        end
        repeat (5) cyc();
        drained("full");
    endtask

    task automatic test_rollback();
        do_reset();
        exp_a(4'd1);
        alu(1'b1, 4'd1);
        lsb(1'b1, 4'd9);
        cyc();
        alu(1'b1, 4'd2);
        lsb(1'b1, 4'd10);
        cyc();
        alu(1'b0, 4'd0);
        lsb(1'b1, 4'd11);
        rollback = 1'b1;
        cyc();
        rollback = 1'b0;
        lsb(1'b0, 4'd0);
        idle_outputs("rb");
        repeat (3) cyc();
        drained("rb");
        exp_a(4'd3);
        exp_l(4'd12);
        alu(1'b1, 4'd3);
        lsb(1'b1, 4'd12);
        cyc();
        alu(1'b0, 4'd0);
        lsb(1'b0, 4'd0);
        repeat (4) cyc();
        drained("rb_after");
    endtask

    task automatic test_stall();
        do_reset();
        exp_a(4'd1);
        exp_l(4'd9);
        exp_a(4'd2);
        exp_l(4'd10);
        alu(1'b1, 4'd1);
        lsb(1'b1, 4'd9);
        cyc();
        alu(1'b1, 4'd2);
        lsb(1'b1, 4'd10);
        cyc();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu(i[0] ? 1'b0 : 1'b1, 4'(6 + i));
            lsb(1'b1, 4'(13 + i));
            rollback = (i == 1);
            cyc();
            checks++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 4'd1 ||
                bus.cdb_val !== aval(4'd1)) begin
                errors++;
                $display("FAIL stall_cdb cyc%0d got v=%b tag=%0d val=%h want v=1 tag=1 val=%h",
                         i, bus.cdb_valid, bus.cdb_tag, bus.cdb_val, aval(4'd1));
            end
            checks++;
            if (bus.alu_ready !== 1'b1 || bus.lsb_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready cyc%0d got %b%b want 10",
                         i, bus.alu_ready, bus.lsb_ready);
            end
        end
        rdy = 1'b1;
        rollback = 1'b0;
        alu(1'b0, 4'd0);
        lsb(1'b0, 4'd0);
        repeat (5) cyc();
        drained("stall");
    endtask

    task automatic test_reset_mid();
        do_reset();
        exp_a(4'd1);
        alu(1'b1, 4'd1);
        lsb(1'b1, 4'd9);
        cyc();
        alu(1'b1, 4'd2);
        lsb(1'b1, 4'd10);
        cyc();
        rst = 1'b1;
        alu(1'b1, 4'd7);
        lsb(1'b0, 4'd0);
        cyc();
        rst = 1'b0;
        alu(1'b0, 4'd0);
        idle_outputs("rstmid");
        repeat (4) cyc();
        drained("rstmid");
    endtask

    initial begin
        alu(1'b0, 4'd0);
        lsb(1'b0, 4'd0);
        test_reset();
        test_latency();
        test_back_to_back();
        test_full();
        test_rollback();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
